// File: rtl/exec_pkg.sv
// exec_pkg: shared encodings for the ALU execute stage (opcodes, shifts, FSM states, status bit indices)
package exec_pkg;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_CMP = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_MVN = 2'b11;
  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL1 = 2'b01;
  localparam logic [1:0] SH_LSR1 = 2'b10;
  localparam logic [1:0] SH_ASR1 = 2'b11;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_RD_B = 3'd2,
    S_EXEC = 3'd3,
    S_WB   = 3'd4
  } state_t;
  localparam int ST_Z = 2;
  localparam int ST_N = 1;
  localparam int ST_V = 0;
endpackage

// File: rtl/exec_shift_alu.sv
// exec_shift_alu: combinational shifter on B, ALU on (A, shifted B) and compare flags {Z,N,V}
//   i_opcode/i_shift : operation and B-shift selects
//   i_a/i_b          : operands
//   o_c              : ALU result
//   o_flags          : {Z,N,V} of A - shifted B
module exec_shift_alu
  import exec_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [1:0]       i_opcode,
  input  logic [1:0]       i_shift,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_c,
  output logic [2:0]       o_flags
);
  logic [WIDTH-1:0] w_sb;
  logic [WIDTH-1:0] w_diff;
  always_comb begin
    w_sb = i_shift == SH_LSL1 ? {i_b[WIDTH-2:0], 1'b0} :
           i_shift == SH_LSR1 ? {1'b0, i_b[WIDTH-1:1]} :
           i_shift == SH_ASR1 ? {i_b[WIDTH-1], i_b[WIDTH-1:1]} : i_b;
    w_diff = i_a - w_sb;
    o_c = i_opcode == OP_ADD ? i_a + w_sb :
          i_opcode == OP_CMP ? w_diff :
          i_opcode == OP_AND ? i_a & w_sb : ~w_sb;
    o_flags = '0;
    o_flags[ST_Z] = w_diff == '0;
    o_flags[ST_N] = w_diff[WIDTH-1];
    // signed overflow: operands of opposite sign and result sign differs from A
    o_flags[ST_V] = (i_a[WIDTH-1] != w_sb[WIDTH-1]) && (w_diff[WIDTH-1] != i_a[WIDTH-1]);
  end
endmodule

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: sequences two regfile reads into A/B, computes C = ALU(A, shift(B)), writes C back
//   i_clk, i_reset_n (sync, active-low)
//   i_start, i_opcode, i_shift, i_rn, i_rm, i_rd : instruction launch (sampled in IDLE)
//   i_rf_data_out : regfile read data for o_readnum
//   o_readnum, o_writenum, o_write, o_data_in : regfile drive
//   o_busy, o_done, o_status {Z,N,V}
// Optional feature: EXEC_SAME_SRC_SKIP_EN skips RD_B when rn == rm.
module alu_exec_stage
  import exec_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AW    = 3
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_start,
  input  logic [1:0]       i_opcode,
  input  logic [1:0]       i_shift,
  input  logic [AW-1:0]    i_rn,
  input  logic [AW-1:0]    i_rm,
  input  logic [AW-1:0]    i_rd,
  input  logic [WIDTH-1:0] i_rf_data_out,
  output logic [AW-1:0]    o_readnum,
  output logic [AW-1:0]    o_writenum,
  output logic             o_write,
  output logic [WIDTH-1:0] o_data_in,
  output logic             o_busy,
  output logic             o_done,
  output logic [2:0]       o_status
);
  state_t           r_state;
  logic [1:0]       r_op;
  logic [1:0]       r_sh;
  logic [AW-1:0]    r_rn;
  logic [AW-1:0]    r_rm;
  logic [AW-1:0]    r_rd;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_c;
  logic [2:0]       r_status;
  logic [AW-1:0]    r_readnum;
  logic [AW-1:0]    r_writenum;
  logic             r_write;
  logic             r_done;
  logic             r_busy;
  logic [WIDTH-1:0] w_c;
  logic [2:0]       w_flags;
  exec_shift_alu #(.WIDTH(WIDTH)) u_alu (
    .i_opcode(r_op),
    .i_shift (r_sh),
    .i_a     (r_a),
    .i_b     (r_b),
    .o_c     (w_c),
    .o_flags (w_flags)
  );
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state    <= S_IDLE;
      r_op       <= '0;
      r_sh       <= '0;
      r_rn       <= '0;
      r_rm       <= '0;
      r_rd       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_c        <= '0;
      r_status   <= '0;
      r_readnum  <= '0;
      r_writenum <= '0;
      r_write    <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_write <= 1'b0;
          r_done  <= 1'b0;
          if (i_start) begin
            r_op      <= i_opcode;
            r_sh      <= i_shift;
            r_rn      <= i_rn;
            r_rm      <= i_rm;
            r_rd      <= i_rd;
            r_readnum <= i_rn;
            r_busy    <= 1'b1;
            r_state   <= S_RD_A;
          end
        end
        S_RD_A: begin
          r_a <= i_rf_data_out;
`ifdef EXEC_SAME_SRC_SKIP_EN
          if (r_rn == r_rm) begin
            r_b     <= i_rf_data_out;
            r_state <= S_EXEC;
          end else begin
            r_readnum <= r_rm;
            r_state   <= S_RD_B;
          end
`else
          r_readnum <= r_rm;
          r_state   <= S_RD_B;
`endif
        end
        S_RD_B: begin
          r_b       <= i_rf_data_out;
          r_readnum <= r_rn;
          r_state   <= S_EXEC;
        end
        S_EXEC: begin
          r_c        <= w_c;
          r_status   <= r_op == OP_CMP ? w_flags : r_status;
          r_writenum <= r_rd;
          r_write    <= r_op != OP_CMP;
          r_done     <= 1'b1;
          r_state    <= S_WB;
        end
        S_WB: begin
          r_write <= 1'b0;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  // a reset landing on the WB edge must suppress the regfile write at that same edge
  assign o_write    = r_write && i_reset_n;
  assign o_readnum  = r_readnum;
  assign o_writenum = r_writenum;
  assign o_data_in  = r_c;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_status   = r_status;
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: randomized + directed bench for alu_exec_stage against a behavioural regfile/ALU model
module tb_alu_exec_stage;
  import exec_pkg::*;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  opcode;
  logic [1:0]  shift;
  logic [2:0]  rn, rm, rd;
  logic [15:0] rf_data_out;
  logic [2:0]  readnum, writenum;
  logic        write, done, busy;
  logic [15:0] data_in;
  logic [2:0]  status;
  logic [15:0] rf [8];
  logic        tb_we = 1'b0;
  logic [2:0]  tb_wa = '0;
  logic [15:0] tb_wd = '0;
  logic [15:0] exp_rf [8];
  logic [2:0]  exp_status;
  int          checks = 0;
  int          errors = 0;
`ifdef EXEC_SAME_SRC_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  always #5 clk = ~clk;
  alu_exec_stage #(.WIDTH(16), .AW(3)) dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_start(start), .i_opcode(opcode), .i_shift(shift),
    .i_rn(rn), .i_rm(rm), .i_rd(rd), .i_rf_data_out(rf_data_out),
    .o_readnum(readnum), .o_writenum(writenum), .o_write(write), .o_data_in(data_in),
    .o_busy(busy), .o_done(done), .o_status(status)
  );
  assign rf_data_out = rf[readnum];
  always @(posedge clk) begin
    if (write) rf[writenum] <= data_in;
    else if (tb_we) rf[tb_wa] <= tb_wd;
  end

  function automatic int shifted(int b, logic [1:0] sh);
    case (sh)
      SH_LSL1: return (b * 2) % 65536;
      SH_LSR1: return b / 2;
      SH_ASR1: return b / 2 + (b >= 32768 ? 32768 : 0);
      default: return b;
    endcase
  endfunction

  task automatic model_op(input logic [1:0] op, input logic [1:0] sh, input logic [2:0] a_r, input logic [2:0] b_r, input logic [2:0] d_r);
    int a, sb, sa, ssb, d, res;
    a = int'(exp_rf[a_r]);
    sb = shifted(int'(exp_rf[b_r]), sh);
    case (op)
      OP_ADD: res = (a + sb) % 65536;
      OP_AND: res = int'(exp_rf[a_r] & 16'(sb));
      OP_MVN: res = 65535 - sb;
      default: res = 0;
    endcase
    if (op == OP_CMP) begin
      sa = a >= 32768 ? a - 65536 : a;
      ssb = sb >= 32768 ? sb - 65536 : sb;
      d = sa - ssb;
      exp_status = {d == 0, ((a - sb + 65536) % 65536) >= 32768, d > 32767 || d < -32768};
    end else exp_rf[d_r] = 16'(res);
  endtask

  task automatic poke(input logic [2:0] a, input logic [15:0] v);
    tb_we = 1'b1; tb_wa = a; tb_wd = v;
    @(posedge clk); #1;
    tb_we = 1'b0;
    exp_rf[a] = v;
  endtask

  task automatic check_rf(input string name);
    for (int r = 0; r < 8; r++) begin
      checks++;
      if (rf[r] !== exp_rf[r]) begin
        errors++;
        $display("FAIL %s rf[%0d]: got %h expected %h", name, r, rf[r], exp_rf[r]);
      end
    end
  endtask

  task automatic launch(input logic [1:0] op, input logic [1:0] sh, input logic [2:0] a_r, input logic [2:0] b_r, input logic [2:0] d_r);
    opcode = op; shift = sh; rn = a_r; rm = b_r; rd = d_r; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [1:0] sh, input logic [2:0] a_r, input logic [2:0] b_r, input logic [2:0] d_r, input string name);
    int lat, dn, wr, exp_lat;
    lat = 0; dn = 0; wr = 0;
    exp_lat = (SKIP && a_r == b_r) ? 2 : 3;
    launch(op, sh, a_r, b_r, d_r);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_after_start: got %b expected 1", name, busy); end
    model_op(op, sh, a_r, b_r, d_r);
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      if (done) begin dn++; if (lat == 0) lat = i; end
      if (write) wr++;
    end
    checks++;
    if (lat != exp_lat) begin errors++; $display("FAIL %s latency: got %0d expected %0d (0 = timeout)", name, lat, exp_lat); end
    checks++;
    if (dn != 1) begin errors++; $display("FAIL %s done_cycles: got %0d expected 1", name, dn); end
    checks++;
    if (wr != (op != OP_CMP ? 1 : 0)) begin errors++; $display("FAIL %s write_cycles: got %0d expected %0d", name, wr, op != OP_CMP ? 1 : 0); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_after_done: got %b expected 0", name, busy); end
    checks++;
    if (status !== exp_status) begin errors++; $display("FAIL %s status: got %b expected %b", name, status, exp_status); end
    check_rf(name);
  endtask

  task automatic preload(input logic [2:0] d_r, input logic [15:0] v);
    poke(3'd0, ~v);
    run_op(OP_MVN, SH_NONE, 3'd0, 3'd0, d_r, "preload");
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b1; opcode = OP_ADD; shift = SH_NONE; rn = 3'd5; rm = 3'd6; rd = 3'd7;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, write, readnum, writenum, data_in, status} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b write=%b rn=%0d wn=%0d data=%h st=%b expected all 0",
               busy, done, write, readnum, writenum, data_in, status);
    end
    start = 1'b0; reset_n = 1'b1;
    exp_status = 3'b000;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_add();
    poke(3'd0, 16'hFFFA);
    run_op(OP_MVN, SH_NONE, 3'd0, 3'd0, 3'd1, "mvn_r1");
    preload(3'd2, 16'h0003);
    run_op(OP_ADD, SH_NONE, 3'd1, 3'd2, 3'd3, "add");
    checks++;
    if (rf[3] !== 16'h0008) begin errors++; $display("FAIL add_r3: got %h expected 0008", rf[3]); end
  endtask

  task automatic test_cmp_equal();
    run_op(OP_CMP, SH_NONE, 3'd1, 3'd1, 3'd0, "cmp_eq");
    checks++;
    if (status !== 3'b100) begin errors++; $display("FAIL cmp_eq_status: got %b expected 100", status); end
  endtask

  task automatic test_cmp_overflow();
    preload(3'd4, 16'h7FFF);
    preload(3'd5, 16'hFFFF);
    run_op(OP_CMP, SH_NONE, 3'd4, 3'd5, 3'd0, "cmp_ovf");
    checks++;
    if (status !== 3'b011) begin errors++; $display("FAIL cmp_ovf_status: got %b expected 011", status); end
  endtask

  task automatic test_mvn_shift();
    preload(3'd6, 16'h8002);
    run_op(OP_MVN, SH_ASR1, 3'd1, 3'd6, 3'd7, "mvn_asr");
    checks++;
    if (rf[7] !== 16'h3FFE) begin errors++; $display("FAIL mvn_asr_r7: got %h expected 3ffe", rf[7]); end
    run_op(OP_MVN, SH_LSR1, 3'd1, 3'd6, 3'd7, "mvn_lsr");
    checks++;
    if (rf[7] !== 16'hBFFE) begin errors++; $display("FAIL mvn_lsr_r7: got %h expected bffe", rf[7]); end
  endtask

  task automatic test_reset_mid();
    run_op(OP_CMP, SH_NONE, 3'd1, 3'd1, 3'd0, "cmp_pre_reset");
    launch(OP_ADD, SH_NONE, 3'd1, 3'd2, 3'd3);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    exp_status = 3'b000;
    checks++;
    if ({busy, write, done, status} !== 6'b0) begin
      errors++;
      $display("FAIL reset_exec: got busy=%b write=%b done=%b status=%b expected 0 0 0 000", busy, write, done, status);
    end
    repeat (3) @(posedge clk);
    #1;
    check_rf("reset_exec");
    launch(OP_ADD, SH_NONE, 3'd1, 3'd2, 3'd5);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL reset_wb_reach: got done=%b expected 1", done); end
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_wb_busy: got %b expected 0", busy); end
    repeat (2) @(posedge clk);
    #1;
    check_rf("reset_wb");
  endtask

  task automatic test_busy_ignore();
    int wr;
    wr = 0;
    launch(OP_ADD, SH_LSL1, 3'd1, 3'd2, 3'd6);
    model_op(OP_ADD, SH_LSL1, 3'd1, 3'd2, 3'd6);
    opcode = OP_MVN; rd = 3'd7; rn = 3'd4; rm = 3'd5; start = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (i == 3) start = 1'b0;
      if (write) begin
        wr++;
        checks++;
        if (writenum !== 3'd6) begin errors++; $display("FAIL busy_ignore_writenum: got %0d expected 6", writenum); end
      end
    end
    checks++;
    if (wr != 1) begin errors++; $display("FAIL busy_ignore_writes: got %0d expected 1", wr); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_ignore_idle: got %b expected 0", busy); end
    check_rf("busy_ignore");
  endtask

  task automatic test_same_src();
    run_op(OP_ADD, SH_NONE, 3'd2, 3'd2, 3'd3, "same_src");
    checks++;
    if (rf[3] !== 16'h0006) begin errors++; $display("FAIL same_src_r3: got %h expected 0006", rf[3]); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++)
      run_op(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
             3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), "random");
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; opcode = '0; shift = '0; rn = '0; rm = '0; rd = '0;
    test_reset();
    for (int r = 0; r < 8; r++) poke(3'(r), 16'($urandom));
    test_add();
    test_cmp_equal();
    test_cmp_overflow();
    test_mvn_shift();
    test_reset_mid();
    test_busy_ignore();
    test_same_src();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
